// File: rtl/tachometer_pulse_generator.sv
// Tachometer emulator: commanded RPM -> 50 % duty tach square wave via a 10 kHz tick and phase accumulator.
// Optional TACH_PULSE_COUNT_EN builds the 32-bit rising-edge counter; otherwise pulse_count_out is 0.
module tachometer_pulse_generator #(
  parameter int TICK_DIV       = 12500,
  parameter int PULSES_PER_REV = 2,
  parameter int MAX_RPM        = 30000
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        enable_in,
  input  logic [20:0] rpm_in,
  input  logic        rpm_valid_in,
  output logic        tach_pulse_out,
  output logic        running_out,
  output logic [31:0] pulse_count_out
);

  // Half an output period expressed in tick-units: 60 s * 10000 ticks/s / 2.
  localparam int HALF    = 300000;
  localparam int MAX_INC = MAX_RPM * PULSES_PER_REV;
  localparam int ACC_W   = $clog2(HALF + MAX_INC) + 1;
  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [20:0]      MAX_RPM_L = 21'(MAX_RPM);
  localparam logic [ACC_W-1:0] HALF_L    = ACC_W'(HALF);
  localparam logic [ACC_W-1:0] PPR_L     = ACC_W'(PULSES_PER_REV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  generate
    if (MAX_INC >= HALF) begin : g_cfg_err
      $error("MAX_RPM*PULSES_PER_REV must be below HALF: at most one toggle per tick");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TICK_W-1:0] r_div;
  logic [20:0]       r_rpm;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              r_tach;
  logic              w_tach_nxt;
  logic              w_tick;
  logic [20:0]       w_rpm_sat;
  logic [ACC_W-1:0]  w_inc;
  logic [ACC_W-1:0]  w_sum;
  logic              w_go;

  assign w_tick    = (r_div == TICK_LAST);
  assign w_rpm_sat = (rpm_in > MAX_RPM_L) ? MAX_RPM_L : rpm_in;
  assign w_inc     = ACC_W'(r_rpm) * PPR_L;
  assign w_sum     = r_acc + w_inc;
  assign w_go      = enable_in && (r_rpm != '0);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_tach_nxt  = r_tach;
    case (r_state)
      ST_IDLE: begin
        w_acc_nxt  = '0;
        w_tach_nxt = 1'b0;
        if (w_go) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!w_go) begin
          // Leaving RUN truncates any high pulse in progress.
          w_state_nxt = ST_IDLE;
          w_acc_nxt   = '0;
          w_tach_nxt  = 1'b0;
        end else if (w_tick) begin
          if (w_sum >= HALF_L) begin
            w_acc_nxt  = w_sum - HALF_L;
            w_tach_nxt = ~r_tach;
          end else begin
            w_acc_nxt = w_sum;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_acc_nxt   = '0;
        w_tach_nxt  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments under an asynchronous, active-low reset.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_div   <= '0;
      r_rpm   <= '0;
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_tach  <= 1'b0;
    end else begin
      r_div   <= w_tick ? '0 : r_div + TICK_W'(1);
      if (rpm_valid_in) r_rpm <= w_rpm_sat;
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_tach  <= w_tach_nxt;
    end
  end

  assign tach_pulse_out = r_tach;
  assign running_out    = (r_state == ST_RUN);

`ifdef TACH_PULSE_COUNT_EN
  logic [31:0] r_pulse_count;
  logic        w_rise;

  // Counts on the same edge the output rises, so it tracks the registered output exactly.
  assign w_rise = w_tach_nxt & ~r_tach;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_pulse_count <= '0;
    end else if (w_rise) begin
      r_pulse_count <= r_pulse_count + 32'd1;
    end
  end

  assign pulse_count_out = r_pulse_count;
`else
  assign pulse_count_out = 32'd0;
`endif

endmodule

// File: tb/tb_tachometer_pulse_generator.sv
// Directed bench for tachometer_pulse_generator: expected toggle edges are queued as stimulus is applied
// and popped by a monitor whenever the tach output changes. TICK_DIV is shortened to keep runs brief.
module tb_tachometer_pulse_generator;

  localparam int TD = 3;
`ifdef TACH_PULSE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [20:0] rpm;
  logic        rpm_valid;
  logic        tach;
  logic        running;
  logic [31:0] pcount;

  int   cyc;
  int   n_cmp;
  int   n_fail;
  ev_t  exp_q[$];
  logic prev_tach;

  tachometer_pulse_generator #(
    .TICK_DIV      (TD),
    .PULSES_PER_REV(2),
    .MAX_RPM       (30000)
  ) dut (
    .clk_in         (clk),
    .reset_n_in     (reset_n),
    .enable_in      (enable),
    .rpm_in         (rpm),
    .rpm_valid_in   (rpm_valid),
    .tach_pulse_out (tach),
    .running_out    (running),
    .pulse_count_out(pcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index since reset release; ticks land on edges where cyc is a multiple of TD.
  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) step();
  endtask

  // Edge of the j-th tick after a RUN entry whose base is floor(entry_edge / TD).
  function automatic int te(input int base, input int j);
    return (base + j) * TD;
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] n);
    return CNT_EN ? n : 32'd0;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_tach = 1'b0;
    end else if (tach !== prev_tach) begin
      prev_tach = tach;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_toggle observed=%b expected=none (cyc %0d)", tach, cyc);
      end
      if (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        check("toggle_edge", cyc, e.cyc);
        check("toggle_value", {31'd0, tach}, {31'd0, e.val});
      end
    end
  end

  initial begin
    int b;
    n_cmp     = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    enable    = 1'b0;
    rpm       = '0;
    rpm_valid = 1'b0;

    // Reset held with random inputs: everything stays zero.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      enable    = 1'($urandom);
      rpm       = 21'($urandom);
      rpm_valid = 1'($urandom);
      #1;
      check("rst_tach", {31'd0, tach}, 32'd0);
      check("rst_running", {31'd0, running}, 32'd0);
      check("rst_count", pcount, 32'd0);
    end
    @(negedge clk);
    enable    = 1'b1;
    rpm       = '0;
    rpm_valid = 1'b0;
    reset_n   = 1'b1;

    // Enabled with rpm_reg == 0: must stay idle.
    repeat (10) step();
    check("idle_zero_rpm_running", {31'd0, running}, 32'd0);
    check("idle_zero_rpm_tach", {31'd0, tach}, 32'd0);

    // 300 RPM -> 10 Hz: toggles every 500 ticks.
    rpm = 21'd300; rpm_valid = 1'b1;
    step();
    rpm_valid = 1'b0;
    check("run_latency_low", {31'd0, running}, 32'd0);
    step();
    check("run_entry", {31'd0, running}, 32'd1);
    b = cyc / TD;
    for (int k = 1; k <= 20; k++) push(te(b, 500 * k), 1'(k % 2));
    wait_until(te(b, 10000) + 1);
    check("count_after_1s", pcount, exp_cnt(32'd10));
    check("queue_after_1s", exp_q.size(), 32'd0);

    // 3000 RPM mid-phase (acc = 150000): first toggle after 25 ticks, then every 50.
    for (int m = 0; m < 6; m++) push(te(b, 10275 + 50 * m), 1'((m + 1) % 2));
    wait_until(te(b, 10250));
    rpm = 21'd3000; rpm_valid = 1'b1;
    step();
    rpm_valid = 1'b0;

    // 30000 RPM with acc = 120000: first toggle after 3 ticks, then every 5.
    for (int m = 0; m < 8; m++) push(te(b, 10548 + 5 * m), 1'((m + 1) % 2));
    wait_until(te(b, 10545));
    rpm = 21'd30000; rpm_valid = 1'b1;
    step();
    rpm_valid = 1'b0;

    // Strobe on a tick edge: that tick still uses the old increment.
    push(te(b, 10615), 1'b1);
    wait_until(te(b, 10585) - 1);
    rpm = 21'd3000; rpm_valid = 1'b1;
    step();
    rpm_valid = 1'b0;

    // 50000 saturates to 30000 -> 5-tick half-period.
    for (int m = 0; m < 4; m++) push(te(b, 10620 + 5 * m), 1'(m % 2));
    wait_until(te(b, 10615));
    rpm = 21'd50000; rpm_valid = 1'b1;
    step();
    rpm_valid = 1'b0;

    // Disable while high: forced low on the next edge, count held.
    wait_until(te(b, 10636));
    check("high_before_disable", {31'd0, tach}, 32'd1);
    push(cyc + 1, 1'b0);
    enable = 1'b0;
    step();
    check("disable_running", {31'd0, running}, 32'd0);
    step();
    check("count_held", pcount, exp_cnt(32'd20));
    check("queue_after_disable", exp_q.size(), 32'd0);

    // Re-enable: restarts from acc = 0 at 30000 RPM.
    repeat (3) step();
    enable = 1'b1;
    step();
    check("reenable_running", {31'd0, running}, 32'd1);
    b = cyc / TD;
    push(te(b, 5), 1'b1);
    push(te(b, 10), 1'b0);
    wait_until(te(b, 10) + 1);
    check("count_reenable", pcount, exp_cnt(32'd21));
    check("queue_reenable", exp_q.size(), 32'd0);
    enable = 1'b0;
    step();

    // 7000 RPM: half-period 150/7 ticks; toggle k at ceil(150k/7).
    rpm = 21'd7000; rpm_valid = 1'b1;
    step();
    rpm_valid = 1'b0;
    step();
    check("disabled_stays_idle", {31'd0, running}, 32'd0);
    enable = 1'b1;
    step();
    b = cyc / TD;
    for (int k = 1; k <= 7; k++) push(te(b, (k * 150 + 6) / 7), 1'(k % 2));
    wait_until(te(b, 150) + 1);
    check("count_7000", pcount, exp_cnt(32'd25));
    check("queue_7000", exp_q.size(), 32'd0);
    push(cyc + 1, 1'b0);
    enable = 1'b0;
    step();
    step();

    // Counter wrap on the next rise.
`ifdef TACH_PULSE_COUNT_EN
    force dut.r_pulse_count = 32'hFFFF_FFFF;
    step();
    release dut.r_pulse_count;
    step();
`endif
    check("count_preload", pcount, exp_cnt(32'hFFFF_FFFF));
    rpm = 21'd30000; rpm_valid = 1'b1;
    step();
    rpm_valid = 1'b0;
    enable = 1'b1;
    step();
    b = cyc / TD;
    push(te(b, 5), 1'b1);
    wait_until(te(b, 5) + 1);
    check("count_wrap", pcount, 32'd0);
    push(cyc + 1, 1'b0);
    enable = 1'b0;
    step();
    step();
    check("queue_final", exp_q.size(), 32'd0);
    check("final_tach", {31'd0, tach}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
